// File: rtl/tx_queue_if.sv
// Byte-producer / serial_tx handshake bundle for tx_queue.
// The slave modport is the queue itself; the master modport is its environment.
interface tx_queue_if #(
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic              i_wr;
  logic [7:0]        i_data;
  logic              o_full;
  logic [ADDR_W:0]   o_count;
  logic              o_ovf;
  logic              o_tx_wr;
  logic [7:0]        o_tx_data;
  logic              i_tx_busy;

  modport slave (
    input  i_wr, i_data, i_tx_busy,
    output o_full, o_count, o_ovf, o_tx_wr, o_tx_data
  );

  modport master (
    output i_wr, i_data, i_tx_busy,
    input  o_full, o_count, o_ovf, o_tx_wr, o_tx_data
  );
endinterface

// File: rtl/tx_queue.sv
// Buffered transmit queue feeding serial_tx one byte at a time.
// Optional CR/LF expansion of popped 8'h0A bytes when CRLF_EXPAND_EN is defined.
module tx_queue #(
  parameter int unsigned DEPTH = 16
) (
  input  logic      i_clk,
  input  logic      i_rst,
  tx_queue_if.slave bus
);
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP, DRAIN} state_t;

  state_t          state, state_nx;
  logic [7:0]      mem [DEPTH];
  logic [ADDR_W:0] wr_ptr, rd_ptr, wr_nx, rd_nx;
  logic [ADDR_W:0] count;
  logic            full, ovf, empty;
  logic            push, pop, tx_wr;
  logic [7:0]      tx_data, head;
`ifdef CRLF_EXPAND_EN
  logic            lf_pending, lf_reload;
`endif

  assign empty = (wr_ptr == rd_ptr);
  assign push  = bus.i_wr && !full;
  assign head  = mem[rd_ptr[ADDR_W-1:0]];
  assign wr_nx = wr_ptr + {{ADDR_W{1'b0}}, push};
  assign rd_nx = rd_ptr + {{ADDR_W{1'b0}}, pop};

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr[ADDR_W-1:0]] <= bus.i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      full       <= 1'b0;
      ovf        <= 1'b0;
      tx_data    <= '0;
`ifdef CRLF_EXPAND_EN
      lf_pending <= 1'b0;
`endif
    end else begin
      state  <= state_nx;
      wr_ptr <= wr_nx;
      rd_ptr <= rd_nx;
      // count/full track the pointers as they will be after this edge
      count  <= wr_nx - rd_nx;
      full   <= (wr_nx[ADDR_W] != rd_nx[ADDR_W]) &&
                (wr_nx[ADDR_W-1:0] == rd_nx[ADDR_W-1:0]);
      if (bus.i_wr && full) begin
        ovf <= 1'b1;
      end
`ifdef CRLF_EXPAND_EN
      if (pop) begin
        if (head == 8'h0A) begin
          tx_data    <= 8'h0D;
          lf_pending <= 1'b1;
        end else begin
          tx_data    <= head;
        end
      end
      if (lf_reload) begin
        tx_data    <= 8'h0A;
        lf_pending <= 1'b0;
      end
`else
      if (pop) begin
        tx_data <= head;
      end
`endif
    end
  end

  always_comb begin
    state_nx  = state;
    pop       = 1'b0;
    tx_wr     = 1'b0;
`ifdef CRLF_EXPAND_EN
    lf_reload = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!empty && !bus.i_tx_busy) begin
          pop      = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        tx_wr    = 1'b1;
        state_nx = GAP;
      end
      GAP: begin
        state_nx = DRAIN;
      end
      DRAIN: begin
        if (!bus.i_tx_busy) begin
`ifdef CRLF_EXPAND_EN
          // second pass for the LF half of an expanded newline, no pop
          if (lf_pending) begin
            lf_reload = 1'b1;
            state_nx  = ISSUE;
          end else begin
            state_nx  = IDLE;
          end
`else
          state_nx = IDLE;
`endif
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.o_full    = full;
  assign bus.o_count   = count;
  assign bus.o_ovf     = ovf;
  assign bus.o_tx_wr   = tx_wr;
  assign bus.o_tx_data = tx_data;
endmodule

// File: tb/tb_tx_queue.sv
// Self-checking bench for tx_queue: directed steps plus random streaming,
// checked against a queue-based model of accepted bytes and expected pulses.
module tb_tx_queue;
  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tx_queue_if #(.DEPTH(DEPTH)) bus ();

  tx_queue #(.DEPTH(DEPTH)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] d;
    bit         pop;
  } pulse_t;

  pulse_t exp_q[$];
  int     n_checks  = 0;
  int     n_fail    = 0;
  int     accepted  = 0;
  int     pops      = 0;
  int     pulses    = 0;
  bit     ovf_model = 1'b0;
  bit     checking  = 1'b0;
  logic   prev_wr   = 1'b0;
  logic   force_busy = 1'b0;
  int     busy_cnt  = 0;

  // serial_tx stand-in: busy for 10 cycles starting the cycle after each pulse
  assign bus.i_tx_busy = force_busy | (busy_cnt != 0);
  always @(posedge clk) begin
    if (bus.o_tx_wr === 1'b1) busy_cnt <= 10;
    else if (busy_cnt != 0)   busy_cnt <= busy_cnt - 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic int pulses_for(input logic [7:0] b);
`ifdef CRLF_EXPAND_EN
    return (b == 8'h0A) ? 2 : 1;
`else
    return 1;
`endif
  endfunction

  function automatic void expect_byte(input logic [7:0] b);
    pulse_t p;
    if (pulses_for(b) == 2) begin
      p.d = 8'h0D; p.pop = 1'b1; exp_q.push_back(p);
      p.d = 8'h0A; p.pop = 1'b0; exp_q.push_back(p);
    end else begin
      p.d = b;     p.pop = 1'b1; exp_q.push_back(p);
    end
  endfunction

  always @(negedge clk) begin
    if (checking) begin
      if (bus.o_tx_wr === 1'b1) begin
        pulses++;
        check("wr_back_to_back", {31'd0, prev_wr}, 32'd0);
        check("wr_while_busy", {31'd0, bus.i_tx_busy}, 32'd0);
        check("pulse_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          check("tx_data", {24'd0, bus.o_tx_data}, {24'd0, exp_q[0].d});
          if (exp_q[0].pop) pops++;
          void'(exp_q.pop_front());
        end
      end
      prev_wr = bus.o_tx_wr;
      check("count", {27'd0, bus.o_count}, accepted - pops);
      check("full", {31'd0, bus.o_full}, {31'd0, (accepted - pops) == int'(DEPTH)});
      check("ovf", {31'd0, bus.o_ovf}, {31'd0, ovf_model});
    end
  end

  // Called just after a negedge; the write lands on the following posedge.
  task automatic drive_wr(input logic [7:0] b, input bit release_busy, output bit ok);
    #1;
    ok = (accepted - pops) < int'(DEPTH);
    if (release_busy) force_busy = 1'b0;
    bus.i_wr   = 1'b1;
    bus.i_data = b;
    @(posedge clk); #1;
    bus.i_wr = 1'b0;
    if (ok) begin
      accepted++;
      expect_byte(b);
    end else begin
      ovf_model = 1'b1;
    end
  endtask

  task automatic wr(input logic [7:0] b);
    bit ok;
    @(negedge clk);
    drive_wr(b, 1'b0, ok);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    accepted  = 0;
    pops      = 0;
    ovf_model = 1'b0;
    exp_q.delete();
    checking  = 1'b1;
  endtask

  task automatic wait_drain(input int budget);
    int i;
    i = 0;
    while ((exp_q.size() != 0 || busy_cnt != 0) && i < budget) begin
      @(negedge clk);
      i++;
    end
    check("drain_in_time", {31'd0, i < budget}, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int p0, want, n, guard;
    bit ok;
    logic [7:0] b;

    bus.i_wr   = 1'b0;
    bus.i_data = 8'h00;
    repeat (3) @(posedge clk);

    // 1: reset values and single-byte latency
    do_reset();
    @(negedge clk);
    check("rst_count", {27'd0, bus.o_count}, 32'd0);
    check("rst_full", {31'd0, bus.o_full}, 32'd0);
    check("rst_ovf", {31'd0, bus.o_ovf}, 32'd0);
    check("rst_tx_wr", {31'd0, bus.o_tx_wr}, 32'd0);
    check("rst_tx_data", {24'd0, bus.o_tx_data}, 32'd0);
    p0 = pulses;
    wr(8'h41);
    @(negedge clk);
    check("lat_n1_wr", {31'd0, bus.o_tx_wr}, 32'd0);
    check("lat_n1_count", {27'd0, bus.o_count}, 32'd1);
    @(negedge clk);
    check("lat_n2_wr", {31'd0, bus.o_tx_wr}, 32'd1);
    check("lat_n2_data", {24'd0, bus.o_tx_data}, 32'h41);
    check("lat_n2_count", {27'd0, bus.o_count}, 32'd0);
    wait_drain(100);
    check("t1_pulses", pulses - p0, 32'd1);

    // 2: fill to full, overflow, ordered drain
    force_busy = 1'b1;
    p0 = pulses;
    want = 0;
    for (int i = 0; i < 16; i++) begin
      b = i[7:0];
      wr(b);
      want += pulses_for(b);
    end
    @(negedge clk);
    check("t2_count_full", {27'd0, bus.o_count}, 32'd16);
    check("t2_full", {31'd0, bus.o_full}, 32'd1);
    check("t2_ovf_before", {31'd0, bus.o_ovf}, 32'd0);
    wr(8'hFF);
    @(negedge clk);
    check("t2_ovf_after", {31'd0, bus.o_ovf}, 32'd1);
    check("t2_count_after", {27'd0, bus.o_count}, 32'd16);
    force_busy = 1'b0;
    wait_drain(1000);
    check("t2_pulses", pulses - p0, want);

    // 3: write while full in the pop cycle is rejected, next cycle accepted
    force_busy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      b = 8'h20 + i[7:0];
      wr(b);
    end
    @(negedge clk);
    drive_wr(8'hAA, 1'b1, ok);
    check("t3_rejected", {31'd0, ok}, 32'd0);
    @(negedge clk);
    check("t3_count_15", {27'd0, bus.o_count}, 32'd15);
    check("t3_full_low", {31'd0, bus.o_full}, 32'd0);
    check("t3_ovf", {31'd0, bus.o_ovf}, 32'd1);
    drive_wr(8'hBB, 1'b0, ok);
    @(negedge clk);
    check("t3_count_16", {27'd0, bus.o_count}, 32'd16);
    check("t3_full_again", {31'd0, bus.o_full}, 32'd1);
    wait_drain(1000);

    // 4: random stream of 40 accepted bytes, pointers wrap
    do_reset();
    p0 = pulses;
    want = 0;
    n = 0;
    guard = 0;
    while (n < 40 && guard < 5000) begin
      guard++;
      if ($urandom_range(0, 1) == 1) begin
        b = 8'($urandom);
        @(negedge clk);
        drive_wr(b, 1'b0, ok);
        if (ok) begin
          n++;
          want += pulses_for(b);
        end
      end else begin
        @(negedge clk);
      end
    end
    check("t4_stream_done", {31'd0, n == 40}, 32'd1);
    wait_drain(2000);
    check("t4_pulses", pulses - p0, want);

    // 5: reset while draining with bytes still queued
    for (int i = 0; i < 6; i++) begin
      b = 8'h30 + i[7:0];
      wr(b);
    end
    @(negedge clk);
    check("t5_queued", {27'd0, bus.o_count}, 32'd5);
    do_reset();
    @(negedge clk);
    check("t5_rst_count", {27'd0, bus.o_count}, 32'd0);
    check("t5_rst_tx_wr", {31'd0, bus.o_tx_wr}, 32'd0);
    check("t5_rst_ovf", {31'd0, bus.o_ovf}, 32'd0);
    p0 = pulses;
    wr(8'h5A);
    wait_drain(200);
    check("t5_pulses", pulses - p0, 32'd1);

    // 6: newline handling
    p0 = pulses;
    wr(8'h0A);
    @(negedge clk);
    check("t6_count_1", {27'd0, bus.o_count}, 32'd1);
    @(negedge clk);
    check("t6_count_0", {27'd0, bus.o_count}, 32'd0);
    check("t6_first_wr", {31'd0, bus.o_tx_wr}, 32'd1);
`ifdef CRLF_EXPAND_EN
    check("t6_first_data", {24'd0, bus.o_tx_data}, 32'h0D);
`else
    check("t6_first_data", {24'd0, bus.o_tx_data}, 32'h0A);
`endif
    wait_drain(200);
    check("t6_pulses", pulses - p0, pulses_for(8'h0A));
    check("t6_count_end", {27'd0, bus.o_count}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
